// File: rtl/z80_spi_pkg.sv
// Shared types and constants for the Z80 SPI master: FSM states, control/status bit positions
// and the idle level of MOSI.
package z80_spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } spi_state_e;

    localparam int CTRL_SSEL    = 0;
    localparam int CTRL_FAST    = 1;
    localparam int CTRL_CLR_OVR = 7;

    localparam int ST_SSEL = 0;
    localparam int ST_FAST = 1;
    localparam int ST_OVR  = 6;
    localparam int ST_BUSY = 7;

    localparam logic MOSI_IDLE = 1'b1;

endpackage

// File: rtl/z80_spi_half_timer.sv
// Loadable down-counter that times one SCK half-period; reload value picks slow or fast
// half-period, and zero_o marks the last phi cycle of the half.
module spi_half_timer #(
    parameter int SLOW_HALF = 12,
    parameter int FAST_HALF = 1
) (
    input  logic phi_i,
    input  logic reset_n_i,
    input  logic fast_i,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int MAX_HALF = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
    localparam int HCW      = $clog2(MAX_HALF + 1);
    localparam logic [HCW-1:0] SLOW_RELOAD = HCW'(SLOW_HALF - 1);
    localparam logic [HCW-1:0] FAST_RELOAD = HCW'(FAST_HALF - 1);

    logic [HCW-1:0] hc_q, hc_d;

    always_comb begin
        hc_d = hc_q;
        if (load_i) begin
            hc_d = fast_i ? FAST_RELOAD : SLOW_RELOAD;
        end else if (dec_i && (hc_q != '0)) begin
            hc_d = hc_q - HCW'(1);
        end
    end

    always_ff @(posedge phi_i) begin
        if (!reset_n_i) begin
            hc_q <= '0;
        end else begin
            hc_q <= hc_d;
        end
    end

    assign zero_o = (hc_q == '0);

endmodule

// File: rtl/z80_spi_master.sv
// Byte-wide SPI mode-0 master on the Z80 IO bus. Define SPI_AUTO_READ_EN to let a data-port
// read in IDLE launch a background 8'hff transfer for streaming reads.
module z80_spi_master
    import z80_spi_pkg::*;
#(
    parameter int SLOW_HALF = 12,
    parameter int FAST_HALF = 1
) (
    input  logic       phi,
    input  logic       reset_n,
    input  logic       wr_data_tick,
    input  logic       wr_ctrl_tick,
    input  logic       rd_data_tick,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic [7:0] status,
    output logic       busy,
    output logic       sd_clk,
    output logic       sd_mosi,
    input  logic       sd_miso,
    output logic       sd_ssel_n
);

    spi_state_e state_q, state_d;
    logic [7:0] sh_q, sh_d;
    logic [2:0] bc_q, bc_d;
    logic [7:0] rdata_q, rdata_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       ssel_q, ssel_d;
    logic       fast_q, fast_d;
    logic       ovr_q, ovr_d;
    logic       hc_load, hc_dec, hc_zero;
    logic       start;
    logic [7:0] start_byte;

    spi_half_timer #(
        .SLOW_HALF(SLOW_HALF),
        .FAST_HALF(FAST_HALF)
    ) u_half_timer (
        .phi_i    (phi),
        .reset_n_i(reset_n),
        .fast_i   (fast_q),
        .load_i   (hc_load),
        .dec_i    (hc_dec),
        .zero_o   (hc_zero)
    );

`ifndef SPI_AUTO_READ_EN
    logic unused_rd;
    assign unused_rd = rd_data_tick;
`endif

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        bc_d       = bc_q;
        rdata_d    = rdata_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ssel_d     = ssel_q;
        fast_d     = fast_q;
        ovr_d      = ovr_q;
        hc_load    = 1'b0;
        hc_dec     = 1'b0;
        start      = 1'b0;
        start_byte = wdata;

        // Ctrl wins over a colliding data write; a data write while not IDLE (including the
        // final HI cycle) is dropped and flagged as overrun.
        if (wr_ctrl_tick) begin
            ssel_d = wdata[CTRL_SSEL];
            fast_d = wdata[CTRL_FAST];
            if (wdata[CTRL_CLR_OVR]) begin
                ovr_d = 1'b0;
            end
        end else if (wr_data_tick) begin
            if (state_q == IDLE) begin
                start = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
`ifdef SPI_AUTO_READ_EN
        end else if (rd_data_tick && (state_q == IDLE)) begin
            start      = 1'b1;
            start_byte = 8'hff;
`endif
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d    = start_byte;
                    mosi_d  = start_byte[7];
                    bc_d    = 3'd0;
                    hc_load = 1'b1;
                    state_d = LO;
                end
            end
            LO: begin
                if (hc_zero) begin
                    sclk_d  = 1'b1;
                    sh_d    = {sh_q[6:0], sd_miso};
                    hc_load = 1'b1;
                    state_d = HI;
                end else begin
                    hc_dec = 1'b1;
                end
            end
            HI: begin
                if (hc_zero) begin
                    sclk_d = 1'b0;
                    if (bc_q == 3'd7) begin
                        rdata_d = sh_q;
                        mosi_d  = MOSI_IDLE;
                        state_d = IDLE;
                    end else begin
                        mosi_d  = sh_q[7];
                        bc_d    = bc_q + 3'd1;
                        hc_load = 1'b1;
                        state_d = LO;
                    end
                end else begin
                    hc_dec = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge phi) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sh_q    <= 8'h00;
            bc_q    <= 3'd0;
            rdata_q <= 8'hff;
            sclk_q  <= 1'b0;
            mosi_q  <= MOSI_IDLE;
            ssel_q  <= 1'b0;
            fast_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bc_q    <= bc_d;
            rdata_q <= rdata_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            ssel_q  <= ssel_d;
            fast_q  <= fast_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        status          = 8'h00;
        status[ST_BUSY] = busy;
        status[ST_OVR]  = ovr_q;
        status[ST_FAST] = fast_q;
        status[ST_SSEL] = ssel_q;
    end

    assign busy      = (state_q != IDLE);
    assign rdata     = rdata_q;
    assign sd_clk    = sclk_q;
    assign sd_mosi   = mosi_q;
    assign sd_ssel_n = ~ssel_q;

endmodule
